// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length encoder/decoder pair.
// Tokens are {marker flag, symbol}; a count token reuses the full token width.
package rle_pkg;

  localparam int SIZE  = 7;
  localparam int LIMIT = 255;
  // Remaining-beat counter must hold LIMIT+1.
  localparam int CNT_W = SIZE + 2;

  typedef struct packed {
    logic [SIZE:0] data;
    logic          valid;
  } out_st;

  typedef struct packed {
    logic [SIZE-1:0] data;
    logic            valid;
  } sym_st;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_CNT,
    EXPAND
  } dec_state_e;

  function automatic logic is_marker(input logic [SIZE:0] tok);
    return tok[SIZE];
  endfunction

  function automatic logic [SIZE-1:0] tok_symbol(input logic [SIZE:0] tok);
    return tok[SIZE-1:0];
  endfunction

  // A count of zero, or one above LIMIT, is malformed but still expanded.
  function automatic logic count_legal(input logic [SIZE:0] n);
    return (n != '0) && ({1'b0, n} <= CNT_W'(LIMIT));
  endfunction

endpackage

// File: rtl/run_length_decoder_if.sv
// Token input and symbol output of the run-length decoder.
// master drives tokens and symbol ready; slave is the decoder.
interface run_length_decoder_if;
  import rle_pkg::*;

  out_st tokenIn;
  logic  symReady;
  sym_st symOut;

  modport master (
    output tokenIn,
    output symReady,
    input  symOut
  );

  modport slave (
    input  tokenIn,
    input  symReady,
    output symOut
  );

endinterface

// File: rtl/rle_token_fifo.sv
// Synchronous token FIFO with a combinational head read.
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module rle_token_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full FIFO is still taken when the head leaves this cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/run_length_decoder.sv
// Run-length decoder: buffers encoded tokens and expands them onto a
// valid/ready symbol stream, flagging FIFO drops and malformed tokens.
module run_length_decoder
  import rle_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  run_length_decoder_if.slave  bus,
  output logic                 overflow,
  output logic                 protoError
);

  dec_state_e       state_q, state_d;
  sym_st            sym_q, sym_d;
  logic [SIZE-1:0]  run_sym_q, run_sym_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic [SIZE:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             can_load;
  logic             drop;

  rle_token_fifo #(
    .WIDTH (SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (bus.tokenIn.valid),
    .wr_data (bus.tokenIn.data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign can_load = !sym_q.valid || bus.symReady;
  assign drop     = bus.tokenIn.valid && fifo_full && !pop;

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    run_sym_d   = run_sym_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q || drop;
    proto_err_d = proto_err_q;
    pop         = 1'b0;

    // Output drops valid once accepted unless a new beat reloads it below.
    if (can_load) sym_d.valid = 1'b0;

    case (state_q)
      FETCH: begin
        if (!fifo_empty && can_load) begin
          pop = 1'b1;
          if (is_marker(head)) begin
            run_sym_d = tok_symbol(head);
            state_d   = WAIT_CNT;
          end else if (tok_symbol(head) == '0) begin
            proto_err_d = 1'b1;
          end else begin
            sym_d.data  = tok_symbol(head);
            sym_d.valid = 1'b1;
          end
        end
      end

      WAIT_CNT: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          remaining_d = {1'b0, head} + CNT_W'(1);
          if (!count_legal(head)) proto_err_d = 1'b1;
          state_d     = EXPAND;
        end
      end

      EXPAND: begin
        if (can_load) begin
          sym_d.data  = run_sym_q;
          sym_d.valid = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      sym_q       <= '0;
      run_sym_q   <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      run_sym_q   <= run_sym_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.symOut = sym_q;
  assign overflow   = overflow_q;
  assign protoError = proto_err_q;

endmodule

// File: tb/tb_run_length_decoder.sv
// Directed bench for run_length_decoder: stimulus pushes expected symbols,
// a negedge monitor pops and compares every accepted beat.
module tb_run_length_decoder;
  import rle_pkg::*;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset_n;
  logic overflow;
  logic protoError;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [SIZE-1:0] exp_q[$];
  int              acc_cyc[$];
  logic            prev_hold = 1'b0;
  logic [SIZE-1:0] prev_data = '0;
  int              t0;

  run_length_decoder_if bus_if ();

  run_length_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus_if.slave),
    .overflow   (overflow),
    .protoError (protoError)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard monitor and hold-stability check.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", int'(bus_if.symOut.valid), 1);
        chk("hold_data", int'(bus_if.symOut.data), int'(prev_data));
      end
      if (bus_if.symOut.valid && bus_if.symReady) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", bus_if.symOut.data);
        end else begin
          chk("beat", int'(bus_if.symOut.data), int'(exp_q.pop_front()));
        end
      end
      prev_hold = bus_if.symOut.valid && !bus_if.symReady;
      prev_data = bus_if.symOut.data;
    end
  end

  // All token tasks start and end at posedge+1.
  task automatic put(input logic flag, input logic [SIZE-1:0] s);
    bus_if.tokenIn.data  = {flag, s};
    bus_if.tokenIn.valid = 1'b1;
    @(posedge clock);
    #1;
    bus_if.tokenIn.valid = 1'b0;
  endtask

  task automatic put_lit(input logic [SIZE-1:0] s);
    if (s != '0) exp_q.push_back(s);
    put(1'b0, s);
  endtask

  task automatic put_run(input logic [SIZE-1:0] s, input logic [SIZE:0] n, input int gap);
    int beats = int'(n) + 1;
    for (int i = 0; i < beats; i++) exp_q.push_back(s);
    put(1'b1, s);
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    bus_if.tokenIn.data  = n;
    bus_if.tokenIn.valid = 1'b1;
    @(posedge clock);
    #1;
    bus_if.tokenIn.valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    chk({name, "_idle"}, int'(bus_if.symOut.valid), 0);
  endtask

  initial begin
    bus_if.tokenIn  = '0;
    bus_if.symReady = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", int'(bus_if.symOut.valid), 0);
    chk("rst_data", int'(bus_if.symOut.data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_proto", int'(protoError), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Three literals back to back: first visible two cycles after it is driven.
    acc_cyc.delete();
    t0 = cyc;
    put_lit(7'h05);
    put_lit(7'h12);
    put_lit(7'h7F);
    drain("lit3", 50);
    chk("lit3_count", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("lit3_latency", acc_cyc[0], t0 + 2);
      chk("lit3_back2back", acc_cyc[2], acc_cyc[0] + 2);
    end

    // Short run followed by a literal with no gap between them.
    acc_cyc.delete();
    put_run(7'h2A, 8'h03, 2);
    put_lit(7'h33);
    drain("run4", 50);
    chk("run4_count", acc_cyc.size(), 5);
    if (acc_cyc.size() == 5) chk("run4_nogap", acc_cyc[4], acc_cyc[0] + 4);

    // Longest legal run.
    acc_cyc.delete();
    put_run(7'h11, 8'hFF, 0);
    drain("run256", 400);
    chk("run256_count", acc_cyc.size(), 256);
    chk("run256_proto", int'(protoError), 0);

    // Same run with a 1,0,0 ready pattern.
    acc_cyc.delete();
    fork
      put_run(7'h11, 8'hFF, 0);
      for (int i = 0; i < 820; i++) begin
        bus_if.symReady = (i % 3 == 0);
        @(posedge clock);
        #1;
      end
    join
    bus_if.symReady = 1'b1;
    drain("run256_bp", 400);
    chk("run256_bp_count", acc_cyc.size(), 256);
    chk("run256_bp_ovf", int'(overflow), 0);

    // Output register absorbs one symbol, so DEPTH+2 writes are needed to overflow.
    acc_cyc.delete();
    bus_if.symReady = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) put_lit(7'(i));
    chk("ovf_before", int'(overflow), 0);
    put(1'b0, 7'h60);
    chk("ovf_after", int'(overflow), 1);
    bus_if.symReady = 1'b1;
    drain("ovf", 100);
    chk("ovf_count", acc_cyc.size(), DEPTH + 1);

    // Zero literal dropped, zero count emits one beat.
    acc_cyc.delete();
    chk("proto_before", int'(protoError), 0);
    put_lit(7'h00);
    put_run(7'h44, 8'h00, 0);
    put_lit(7'h55);
    drain("proto", 50);
    chk("proto_after", int'(protoError), 1);
    chk("proto_count", acc_cyc.size(), 2);

    // Reset in the middle of a 100-beat run.
    put_run(7'h22, 8'h63, 0);
    repeat (40) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus_if.symOut.valid), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_proto", int'(protoError), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    acc_cyc.delete();
    repeat (5) @(posedge clock);
    #1;
    chk("postrst_idle", acc_cyc.size(), 0);
    t0 = cyc;
    put_lit(7'h3C);
    drain("postrst", 50);
    chk("postrst_count", acc_cyc.size(), 1);
    if (acc_cyc.size() == 1) chk("postrst_latency", acc_cyc[0], t0 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
